// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative RV32M divider: func3 op codes and FSM encodings.
package div_unit_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake: launch request in, hold/write-back out.
interface div_unit_if #(parameter int XLEN = 32);

  logic            start_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            hold_flag_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] rd_wdata_o;
  logic [4:0]      rd_waddr_o;
  logic            reg_wen_o;

  modport master (
    output start_i, func3_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  hold_flag_o, busy_o, valid_o, rd_wdata_o, rd_waddr_o, reg_wen_o
  );

  modport slave (
    input  start_i, func3_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output hold_flag_o, busy_o, valid_o, rd_wdata_o, rd_waddr_o, reg_wen_o
  );

endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign fix-up on DONE entry, result handed to write-back with a one-cycle valid.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dvd_q;   // shifts dividend bits out, quotient bits in
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN-1:0]  rem_q;
  logic             op_rem_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic [4:0]       rd_addr_q;
  logic             valid_q;
  logic [XLEN-1:0]  wdata_q;
  logic [4:0]       waddr_q;

  logic             start_ok;
  logic             is_signed;
  logic             op_rem;
  logic             sign_a;
  logic             sign_b;
  logic             cnt_last;
  logic [XLEN:0]    partial;
  logic [XLEN:0]    trial;
  logic             q_bit;
  logic [XLEN-1:0]  quot_nxt;
  logic [XLEN-1:0]  rem_nxt;
  logic [XLEN-1:0]  result;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic signed_op);
    return (signed_op && v[XLEN-1]) ? -v : v;
  endfunction

  assign start_ok  = (state == S_IDLE) && bus.start_i && !bus.flush_i;
  assign is_signed = (bus.func3_i == INST_DIV) || (bus.func3_i == INST_REM);
  assign op_rem    = (bus.func3_i == INST_REM) || (bus.func3_i == INST_REMU);
  assign sign_a    = is_signed && bus.dividend_i[XLEN-1];
  assign sign_b    = is_signed && bus.divisor_i[XLEN-1];
  assign cnt_last  = (cnt == CNT_W'(XLEN - 1));

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    partial  = {rem_q, dvd_q[XLEN-1]};
    trial    = partial - {1'b0, dvs_q};
    q_bit    = ~trial[XLEN];   // top bit set means the trial subtraction borrowed
    quot_nxt = {dvd_q[XLEN-2:0], q_bit};
    rem_nxt  = q_bit ? trial[XLEN-1:0] : partial[XLEN-1:0];
    if (op_rem_q) result = neg_rem_q  ? -rem_nxt  : rem_nxt;
    else          result = neg_quot_q ? -quot_nxt : quot_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      valid_q <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      if (bus.flush_i) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            if (bus.start_i) begin
              if (bus.divisor_i == '0) begin
                state   <= S_DONE;
                valid_q <= 1'b1;
                wdata_q <= op_rem ? bus.dividend_i : '1;
                waddr_q <= bus.rd_addr_i;
              end else begin
                state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt_last) begin
              state   <= S_DONE;
              valid_q <= 1'b1;
              wdata_q <= result;
              waddr_q <= rd_addr_q;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // NOTE: the datapath needs no reset; it is always loaded on launch before it is used.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.start_i) begin
      dvd_q      <= magnitude(bus.dividend_i, is_signed);
      dvs_q      <= magnitude(bus.divisor_i, is_signed);
      rem_q      <= '0;
      op_rem_q   <= op_rem;
      neg_quot_q <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
      rd_addr_q  <= bus.rd_addr_i;
    end else if (state == S_CALC) begin
      dvd_q <= quot_nxt;
      rem_q <= rem_nxt;
    end
  end

  assign bus.hold_flag_o = start_ok || (state == S_CALC);
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.valid_o     = valid_q;
  assign bus.reg_wen_o   = valid_q;
  assign bus.rd_wdata_o  = wdata_q;
  assign bus.rd_waddr_o  = waddr_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard queue filled at launch, drained by a
// result monitor that also checks write address, write enable and latency.
module tb_div_unit;
  import div_unit_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [4:0]  addr;
    int          start_cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'b0, bus.valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_wdata"}, bus.rd_wdata_o, e.data);
        check({e.tag, "_waddr"}, {27'b0, bus.rd_waddr_o}, {27'b0, e.addr});
        check({e.tag, "_wen"}, {31'b0, bus.reg_wen_o}, 32'd1);
        check({e.tag, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    bus.start_i    = 1'b1;
    bus.func3_i    = f3;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_addr_i  = rd;
  endtask

  task automatic launch(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    exp_t e;
    drive_start(f3, a, b, rd);
    e.tag = tag; e.data = exp; e.addr = rd; e.start_cyc = cyc; e.lat = lat;
    sb.push_back(e);
  endtask

  // Waits for the scoreboard to empty, then steps into the following IDLE cycle.
  task automatic wait_drain(input string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    tick();
    check({tag, "_valid_pulse"}, {31'b0, bus.valid_o}, 32'd0);
    check({tag, "_wdata_idle"}, bus.rd_wdata_o, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    launch(tag, f3, a, b, rd, exp, lat);
    tick();
    bus.start_i = 1'b0;
    wait_drain(tag);
  endtask

  initial begin
    int hcount;
    int guard;

    bus.start_i = 1'b0; bus.func3_i = '0; bus.dividend_i = '0; bus.divisor_i = '0;
    bus.rd_addr_i = '0; bus.flush_i = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy",  {31'b0, bus.busy_o},      32'd0);
    check("rst_valid", {31'b0, bus.valid_o},     32'd0);
    check("rst_hold",  {31'b0, bus.hold_flag_o}, 32'd0);
    check("rst_wen",   {31'b0, bus.reg_wen_o},   32'd0);
    check("rst_wdata", bus.rd_wdata_o,           32'd0);
    check("rst_waddr", {27'b0, bus.rd_waddr_o},  32'd0);
    rst = 1'b0;
    tick();

    // Unsigned and signed basics; each starts in the IDLE cycle right after DONE
    run_op("divu_100_7", INST_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
    run_op("remu_100_7", INST_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33);
    run_op("div_m7_2",   INST_DIV,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   INST_REM,  32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2",   INST_DIV,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",   INST_REM,  32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1, 33);
    run_op("divu_max_1", INST_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 33);
    run_op("remu_max_16", INST_REMU, 32'hFFFF_FFFF, 32'd16, 5'd1, 32'd15, 33);

    // Divide by zero: result one cycle after start, hold only in the start cycle
    launch("divu_5_0", INST_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    #1;
    check("div0_hold_start", {31'b0, bus.hold_flag_o}, 32'd1);
    tick();
    bus.start_i = 1'b0;
    check("div0_hold_done", {31'b0, bus.hold_flag_o}, 32'd0);
    wait_drain("divu_5_0");
    run_op("rem_m5_0", INST_REM, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, 1);

    // Signed overflow, with hold counted over every pre-DONE cycle
    launch("div_ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 33);
    #1;
    hcount = bus.hold_flag_o ? 1 : 0;
    tick();
    bus.start_i = 1'b0;
    guard = 0;
    while (bus.valid_o !== 1'b1 && guard < 40) begin
      if (bus.hold_flag_o) hcount++;
      tick();
      guard++;
    end
    check("ovf_hold_cycles", 32'(hcount), 32'd33);
    check("ovf_hold_in_done", {31'b0, bus.hold_flag_o}, 32'd0);
    wait_drain("div_ovf");
    run_op("rem_ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 33);

    // Flush mid-calculation: no result, idle next cycle, then an immediate new op
    drive_start(INST_DIVU, 32'd1000, 32'd3, 5'd15);
    tick();
    bus.start_i = 1'b0;
    repeat (9) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush_busy", {31'b0, bus.busy_o}, 32'd0);
    check("flush_hold", {31'b0, bus.hold_flag_o}, 32'd0);
    run_op("divu_9_3", INST_DIVU, 32'd9, 32'd3, 5'd16, 32'd3, 33);

    // A second start during CALC is ignored
    launch("divu_ign", INST_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 33);
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    check("calc_busy", {31'b0, bus.busy_o}, 32'd1);
    drive_start(INST_DIVU, 32'd50, 32'd5, 5'd4);
    tick();
    bus.start_i = 1'b0;
    wait_drain("divu_ign");

    // Reset mid-operation: everything zero, no result afterwards
    drive_start(INST_DIV, 32'd1000, 32'd7, 5'd18);
    tick();
    bus.start_i = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",  {31'b0, bus.busy_o},      32'd0);
    check("mid_rst_valid", {31'b0, bus.valid_o},     32'd0);
    check("mid_rst_hold",  {31'b0, bus.hold_flag_o}, 32'd0);
    check("mid_rst_wen",   {31'b0, bus.reg_wen_o},   32'd0);
    check("mid_rst_wdata", bus.rd_wdata_o,           32'd0);
    repeat (40) tick();
    check("post_rst_busy", {31'b0, bus.busy_o}, 32'd0);

    // Unit still works after the abort
    run_op("rem_after_rst", INST_REM, 32'hFFFF_FF9C, 32'd7, 5'd19, 32'hFFFF_FFFE, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider serving DIV, DIVU, REM and REMU. The execute stage launches it with a one-cycle start, and it stalls the pipeline via `hold_flag_o` while computing. On completion it returns the quotient or remainder with a register write request to the writeback/regs path. It is the multi-cycle responder to the execute stage: execute initiates, this unit answers with hold and write-back.

## Interface
Parameters:
- `XLEN`, 32, operand and result width
- `CNT_W`, 6, iteration counter width (≥ log2(XLEN)+1)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start_i`  in  1  launch request, sampled only in IDLE
- `func3_i`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- `dividend_i`  in  XLEN  rs1 value
- `divisor_i`  in  XLEN  rs2 value
- `rd_addr_i`  in  5  destination register
- `flush_i`  in  1  jump/flush from ctrl; aborts any operation
- `hold_flag_o`  out  1  pipeline stall request to ctrl
- `busy_o`  out  1  state != IDLE
- `valid_o`  out  1  result valid, one-cycle pulse
- `rd_wdata_o`  out  XLEN  quotient or remainder
- `rd_waddr_o`  out  5  destination register
- `reg_wen_o`  out  1  write enable, equals `valid_o`

## Operation
- States:
  - IDLE.
  - CALC: restoring division, 1 quotient bit per cycle, counter 0..XLEN-1.
  - DONE: outputs presented for one cycle.
- IDLE to CALC: on `start_i` and !`flush_i`, latch func3, rd_addr, operand magnitudes and sign flags.
  - Signed ops use |a|, |b|; unsigned ops use the raw values.
- Divide-by-zero: if `divisor_i`==0 when start is sampled, go directly IDLE to DONE.
  - Quotient = all ones.
  - Remainder = dividend, unmodified.
- Signed result fix-up in DONE entry:
  - Quotient negated if sign(a)^sign(b).
  - Remainder negated if sign(a).
- Overflow (0x80000000 / 0xFFFFFFFF, DIV) needs no special path; it yields quotient 0x80000000, remainder 0.
- Remainder/partial register width is XLEN+1 to hold the trial subtraction borrow.
- CALC to DONE after the XLEN-th iteration. DONE to IDLE unconditionally.
- `start_i` while not in IDLE: ignored; the caller holds on `hold_flag_o`.
- `flush_i` in any state: next state IDLE, no `valid_o`, latched data discarded. `flush_i` and `start_i` in the same cycle: flush wins.
- `hold_flag_o` = (IDLE & `start_i` & !`flush_i`) | CALC. It is low in DONE so the pipeline resumes as the result writes back.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `busy_o`, `valid_o`, `reg_wen_o`, `hold_flag_o` all 0.
  - `rd_wdata_o` and `rd_waddr_o` 0.
- `rst` mid-operation: same as reset; no result is ever emitted for the aborted op.
- Normal latency: start sampled at edge E0, iterations on E1..E32, DONE entered at E32. `valid_o` is high between E32 and E33, i.e. 33 cycles after the start cycle.
- Divide-by-zero latency: DONE entered at E0; `valid_o` high for the cycle after E0.
- `rd_wdata_o`, `rd_waddr_o`, `reg_wen_o` are registered, driven only in DONE, and zero otherwise (no stale writes).
- Back-to-back: a new `start_i` is accepted in the cycle immediately after DONE, i.e. IDLE at E33.

## Structure
- `INST_DIV`, `INST_DIVU`, `INST_REM`, `INST_REMU` func3 codes and the state encodings go in the shared `defines.v`.
- Single module, no sub-module. The sign/magnitude conversion is a local function.
- Execute-stage integration: for an R_M opcode with func7=0000001 and func3[2]=1, raise `start_i` and merge `hold_flag_o` into the existing hold path.

## Test plan
- DIVU 100 / 7 → `valid_o` 33 cycles after start, `rd_wdata_o`=14; REMU same operands → 2; `rd_waddr_o` echoes rd_addr, `reg_wen_o`=1 for one cycle.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIV 7 / -2 → 0xFFFFFFFD; REM 7 / -2 → 1.
- DIVU 5 / 0 → 0xFFFFFFFF one cycle after start; REM -5 / 0 → 0xFFFFFFFB; `hold_flag_o` high only in the start cycle.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0; check `hold_flag_o` high for all 33 pre-DONE cycles and low in DONE.
- Start DIVU 1000/3, assert `flush_i` at cycle 10 → no `valid_o`, `busy_o`=0 next cycle. An immediate new DIVU 9/3 → 3 at normal latency.
- Second `start_i` pulses during CALC are ignored, so the first result is unchanged. `rst` asserted at cycle 20 → all outputs 0 next cycle, no `valid_o` afterward.
